// File: rtl/adc_conversion_sequencer.sv
// Sequences SAR ADC conversions: latches config, pulses start, waits for a synchronised done edge
// with timeout, and buffers results in a show-ahead FIFO.
module adc_conversion_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned START_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          single_shot,
    input  logic [15:0]                   period,
    input  logic [15:0]                   config_1_cfg,
    input  logic [15:0]                   config_2_cfg,
    output logic [15:0]                   config_1_out,
    output logic [15:0]                   config_2_out,
    output logic                          start_conversion_out,
    input  logic                          conversion_finished_in,
    input  logic [15:0]                   result_in,
    input  logic                          fifo_rd,
    output logic [15:0]                   fifo_data,
    output logic                          fifo_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic                          timeout_err,
    input  logic                          clear_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = $clog2(START_W + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SW-1:0] START_LAST = SW'(START_W - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StStart   = 3'd2;
    localparam logic [2:0] StWait    = 3'd3;
    localparam logic [2:0] StCapture = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] start_cnt_q, start_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]   timer_q;
    logic [15:0]   config_1_q, config_2_q;
    logic          fin_meta_q, fin_sync_q, fin_prev_q;
    logic          fin_rise;
    logic          load, push, timeout_set;

    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, pop, push_ok, overflow_set;
    logic          overflow_q, timeout_err_q;

    assign fin_rise = fin_sync_q & ~fin_prev_q;

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        push        = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (single_shot || (enable && timer_q == '0)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d     = StStart;
                start_cnt_d = '0;
            end
            StStart: begin
                if (start_cnt_q == START_LAST) begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (fin_rise) begin
                    state_d = StCapture;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = StIdle;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StCapture: begin
                state_d = StIdle;
                push    = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Config and timer register on the edge into LOAD so they are visible during the LOAD cycle.
    assign load = (state_q == StIdle) && (state_d == StLoad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timer_q     <= '0;
            config_1_q  <= '0;
            config_2_q  <= '0;
            fin_meta_q  <= 1'b0;
            fin_sync_q  <= 1'b0;
            fin_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            fin_meta_q  <= conversion_finished_in;
            fin_sync_q  <= fin_meta_q;
            fin_prev_q  <= fin_sync_q;
            if (load) begin
                config_1_q <= config_1_cfg;
                config_2_q <= config_2_cfg;
                // The LOAD cycle's own decrement is folded in, keeping start edges period apart.
                timer_q    <= (period == '0) ? '0 : period - 16'd1;
            end else if (timer_q != '0) begin
                timer_q <= timer_q - 16'd1;
            end
        end
    end

    assign full         = (count_q == FULL_COUNT);
    assign pop          = fifo_rd && (count_q != '0);
    assign push_ok      = push && (!full || pop);
    assign overflow_set = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= result_in;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (clear_err) begin
                overflow_q <= 1'b0;
            end
            if (timeout_set) begin
                timeout_err_q <= 1'b1;
            end else if (clear_err) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign config_1_out         = config_1_q;
    assign config_2_out         = config_2_q;
    assign start_conversion_out = (state_q == StStart);
    assign busy                 = (state_q != StIdle);
    assign fifo_data            = mem_q[rd_ptr_q];
    assign fifo_valid           = (count_q != '0);
    assign fifo_count           = count_q;
    assign overflow             = overflow_q;
    assign timeout_err          = timeout_err_q;

endmodule

// File: doc/adc_conversion_sequencer.md
Name: adc_conversion_sequencer

Overview:
- Digital controller that sequences conversions of the SAR ADC top block.
- Latches the config_1/config_2 words, issues start_conversion pulses (single-shot or periodic), and waits for conversion_finished with a timeout.
- Captures each 16-bit result into a small show-ahead FIFO for the system bus.
- Sits between the register/bus interface and the ADC top; runs on the system clock, asynchronous to the ADC internal clock loop.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- START_W, 4, width of start_conversion_out pulse in clk cycles; at least 1.
- TIMEOUT_CYCLES, 1023, maximum WAIT cycles before abort; at least 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  periodic conversion mode enable.
- single_shot  in  1  one-cycle pulse; requests one conversion.
- period  in  16  minimum clk cycles between successive start pulses (periodic mode).
- config_1_cfg  in  16  config word 1 from register file.
- config_2_cfg  in  16  config word 2 from register file.
- config_1_out  out  16  latched config word 1 to ADC.
- config_2_out  out  16  latched config word 2 to ADC.
- start_conversion_out  out  1  start request to ADC.
- conversion_finished_in  in  1  ADC done flag; asynchronous to clk.
- result_in  in  16  ADC result; stable while finished is high.
- fifo_rd  in  1  pop head entry.
- fifo_data  out  16  head entry; valid when fifo_valid=1.
- fifo_valid  out  1  FIFO not empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of occupied entries.
- busy  out  1  state is not IDLE.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- timeout_err  out  1  sticky: a conversion timed out.
- clear_err  in  1  clears overflow and timeout_err.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, period timer 0, synchronizer flops 0.
- conversion_finished_in passes through a 2-flop synchronizer followed by a rising-edge detector (fin_rise). Only fin_rise is used; a level that is already high at WAIT entry is never treated as done.
- FSM states:
  - IDLE → LOAD when single_shot=1, or when enable=1 and timer=0.
  - LOAD (1 cycle): config_*_out <= config_*_cfg; timer <= period. Next state START.
  - START (START_W cycles): start_conversion_out=1. Next state WAIT; start_conversion_out drops to 0 on entry to WAIT.
  - WAIT: the wait counter resets on entry.
    - fin_rise=1 → CAPTURE.
    - Counter reaches TIMEOUT_CYCLES → set timeout_err and go to IDLE with no push.
  - CAPTURE (1 cycle): push result_in, then go to IDLE.
- Latency: a single_shot at cycle t gives config_*_out updated at t+1 and start_conversion_out high for cycles t+2 .. t+1+START_W.
- Config outputs change only in LOAD; they are stable for the whole conversion.
- Period timer:
  - Decrements once per cycle in every state, saturating at 0.
  - period=0 gives back-to-back conversions; the next LOAD follows immediately after CAPTURE→IDLE.
- single_shot outside IDLE is ignored, not queued.
- enable deasserted mid-conversion: the current conversion completes and is captured; no new trigger follows.
- FIFO behaviour:
  - Show-ahead: fifo_data equals the head entry whenever fifo_valid=1.
  - fifo_rd while empty is ignored.
  - Push while full, with no pop in the same cycle: the new sample is dropped and overflow is set. Existing contents are unchanged.
  - Push and pop in the same cycle while full: the pop is applied first, the push is accepted, count is unchanged, and overflow is not set.
  - Push and pop in the same cycle while empty: the entry is written, count becomes 1, and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: clear_err clears overflow and timeout_err. If a set event and clear_err occur in the same cycle, the set wins.
- busy=1 in LOAD, START, WAIT and CAPTURE.
- rst asserted in any state: next cycle the state is IDLE, start_conversion_out=0, FIFO is flushed, and flags and config outputs are 0.

Test Plan:
1. Single shot: config_1_cfg=16'h0C05, pulse single_shot at t → config_1_out=16'h0C05 at t+1; start high t+2..t+5. Raise finished with result_in=16'h0ABC → after sync, fifo_valid=1, fifo_data=16'h0ABC, fifo_count=1, busy=0.
2. Periodic: enable=1, period=100, ADC model finishes after 20 cycles → start rising edges exactly 100 cycles apart. With period=0 → next LOAD on the cycle after CAPTURE→IDLE.
3. Overflow: 5 conversions with results 1..5 and no reads → fifo_count=4, overflow=1, pops return 1,2,3,4. clear_err → overflow=0.
4. Timeout: finished held low → after TIMEOUT_CYCLES in WAIT, timeout_err=1, state IDLE, fifo_count unchanged. finished held high before START → still times out (no level detection).
5. Full with simultaneous push and pop: FIFO full, fifo_rd coincides with CAPTURE → count stays 4, overflow=0, order preserved.
6. Reset mid-WAIT: assert rst → next cycle start_conversion_out=0, busy=0, fifo_count=0, config_*_out=0, flags=0. A late finished edge afterwards produces no push.
